// File: rtl/priority_display_pkg.sv
// Shared types, segment constants and hex font for the priority encoder display.
package priority_display_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Active-high segment font, bit0 = a ... bit6 = g
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      4'hF:    seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble to 7-segment decoder wrapping the package font.
module seg7_hex_decoder
  import priority_display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_segments
);

  assign o_segments = hex_to_seg(i_nibble);

endmodule

// File: rtl/priority_encoder_scan_display.sv
// Two-stage priority encoder with live/latched capture, driving a scanned
// multi-digit hex 7-segment display.
module priority_encoder_scan_display
  import priority_display_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DIGITS   = 2,
  parameter int SCAN_DIV = 1024,
  localparam int IDXW    = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [WIDTH-1:0]  data,
  input  logic              mode_latch,
  input  logic              clear,
  output logic [IDXW-1:0]   index,
  output logic              valid,
  output logic              no_data,
  output logic [6:0]        segments,
  output logic [DIGITS-1:0] digit_en
);

  localparam int PW  = ($clog2(SCAN_DIV) < 1) ? 1 : $clog2(SCAN_DIV);
  localparam int DPW = ($clog2(DIGITS) < 1) ? 1 : $clog2(DIGITS);

  logic [WIDTH-1:0]    r_data_q;
  state_t              r_state;
  logic [IDXW-1:0]     r_index;
  logic                r_valid;
  logic                r_no_data;
  logic [PW-1:0]       r_pre;
  logic [DPW-1:0]      r_ptr;
  logic [DIGITS-1:0]   r_digit_en;
  logic [6:0]          r_segments;

  logic                w_hit;
  logic [IDXW-1:0]     w_enc;
  state_t              w_state_nxt;
  logic [IDXW-1:0]     w_index_nxt;
  logic                w_valid_nxt;
  logic [PW-1:0]       w_pre_nxt;
  logic [DPW-1:0]      w_ptr_nxt;
  logic [4*DIGITS-1:0] w_idx_ext;
  logic [3:0]          w_nibble;
  logic [6:0]          w_dec_seg;
  logic [6:0]          w_seg_nxt;
  logic [DIGITS-1:0]   w_den_nxt;

  // Ascending scan so the highest set bit wins
  always_comb begin
    w_hit = 1'b0;
    w_enc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (r_data_q[i]) begin
        w_hit = 1'b1;
        w_enc = IDXW'(i);
      end else begin
        w_hit = w_hit;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_index_nxt = r_index;
    w_valid_nxt = r_valid;
    if (!mode_latch) begin
      w_state_nxt = IDLE;
      w_valid_nxt = w_hit;
      if (w_hit) w_index_nxt = w_enc;
      else       w_index_nxt = r_index;
    end else begin
      case (r_state)
        IDLE: begin
          w_valid_nxt = w_hit;
          if (w_hit) begin
            w_index_nxt = w_enc;
            w_state_nxt = HOLD;
          end else begin
            w_index_nxt = r_index;
          end
        end
        HOLD: begin
          // A release discards this cycle's encode; capture restarts next edge
          if (clear) begin
            w_state_nxt = IDLE;
            w_valid_nxt = 1'b0;
          end else begin
            w_state_nxt = HOLD;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_pre_nxt = r_pre + PW'(1);
    w_ptr_nxt = r_ptr;
    if (r_pre == PW'(SCAN_DIV - 1)) begin
      w_pre_nxt = '0;
      if (r_ptr == DPW'(DIGITS - 1)) w_ptr_nxt = '0;
      else                           w_ptr_nxt = r_ptr + DPW'(1);
    end else begin
      w_ptr_nxt = r_ptr;
    end
  end

  // Display content is derived from next-state values so segments match digit_en
  always_comb begin
    w_idx_ext              = '0;
    w_idx_ext[IDXW-1:0]    = w_index_nxt;
    w_nibble               = 4'h0;
    w_den_nxt              = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (w_ptr_nxt == DPW'(d)) begin
        w_nibble     = w_idx_ext[d*4 +: 4];
        w_den_nxt[d] = 1'b1;
      end else begin
        w_den_nxt[d] = 1'b0;
      end
    end
  end

  seg7_hex_decoder u_dec (
    .i_nibble   (w_nibble),
    .o_segments (w_dec_seg)
  );

  always_comb begin
    if (w_valid_nxt)             w_seg_nxt = w_dec_seg;
    else if (w_ptr_nxt == '0)    w_seg_nxt = SEG_DASH;
    else                         w_seg_nxt = SEG_BLANK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_q   <= '0;
      r_state    <= IDLE;
      r_index    <= '0;
      r_valid    <= 1'b0;
      r_no_data  <= 1'b1;
      r_pre      <= '0;
      r_ptr      <= '0;
      r_digit_en <= DIGITS'(1);
      r_segments <= SEG_DASH;
    end else if (ena) begin
      r_data_q   <= data;
      r_state    <= w_state_nxt;
      r_index    <= w_index_nxt;
      r_valid    <= w_valid_nxt;
      r_no_data  <= ~w_valid_nxt;
      r_pre      <= w_pre_nxt;
      r_ptr      <= w_ptr_nxt;
      r_digit_en <= w_den_nxt;
      r_segments <= w_seg_nxt;
    end
  end

  assign index    = r_index;
  assign valid    = r_valid;
  assign no_data  = r_no_data;
  assign segments = r_segments;
  assign digit_en = r_digit_en;

endmodule

// File: tb/tb_priority_encoder_scan_display.sv
// Directed plus randomized bench for priority_encoder_scan_display against a
// cycle-level behavioural model (WIDTH=16, DIGITS=2, SCAN_DIV=4).
module tb_priority_encoder_scan_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b1;
  logic [15:0] data = 16'h0000;
  logic        mode_latch = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  index;
  logic        valid;
  logic        no_data;
  logic [6:0]  segments;
  logic [1:0]  digit_en;

  int total = 0;
  int bad   = 0;

  // Model state: captured request, displayed result, capture flag, enabled-cycle count
  int m_dq, m_idx, m_cnt;
  bit m_valid, m_hold;

  logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  priority_encoder_scan_display #(.WIDTH(16), .DIGITS(2), .SCAN_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .data       (data),
    .mode_latch (mode_latch),
    .clear      (clear),
    .index      (index),
    .valid      (valid),
    .no_data    (no_data),
    .segments   (segments),
    .digit_en   (digit_en)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int highest(input int v);
    for (int b = 15; b >= 0; b--) if ((v >> b) & 1) return b;
    return -1;
  endfunction

  task automatic model_update();
    int h;
    if (rst) begin
      m_dq = 0; m_idx = 0; m_valid = 0; m_hold = 0; m_cnt = 0;
    end else if (ena) begin
      h = highest(m_dq);
      if (!mode_latch || !m_hold) begin
        m_hold  = mode_latch && (h >= 0);
        m_valid = (h >= 0);
        if (h >= 0) m_idx = h;
      end else if (clear) begin
        m_hold  = 0;
        m_valid = 0;
      end
      m_dq = int'(data);
      m_cnt++;
    end
  endtask

  task automatic step();
    int ptr;
    logic [6:0] exp_seg;
    @(posedge clk);
    model_update();
    #1;
    ptr = (m_cnt / 4) % 2;
    if (m_valid) exp_seg = font[(m_idx >> (4 * ptr)) & 15];
    else         exp_seg = (ptr == 0) ? 7'h40 : 7'h00;
    chk("index",    32'(index),    32'(m_idx));
    chk("valid",    32'(valid),    32'(m_valid));
    chk("no_data",  32'(no_data),  32'(!m_valid));
    chk("digit_en", 32'(digit_en), 32'(2'b01 << ptr));
    chk("segments", 32'(segments), 32'(exp_seg));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_digit(input logic [1:0] want);
    int n = 0;
    while (digit_en !== want && n < 10) begin
      step();
      n++;
    end
    chk("wait_digit", 32'(digit_en), 32'(want));
  endtask

  task automatic count_until_change(output int n);
    logic [1:0] prev;
    prev = digit_en;
    n = 0;
    while (n < 20) begin
      step();
      n++;
      if (digit_en !== prev) break;
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    step();
    chk("rst_index",   32'(index),    32'd0);
    chk("rst_valid",   32'(valid),    32'd0);
    chk("rst_no_data", 32'(no_data),  32'd1);
    chk("rst_den",     32'(digit_en), 32'h1);
    chk("rst_seg",     32'(segments), 32'h40);
    rst = 1'b0;

    // Live mode
    data = 16'h0028;
    run(2);
    chk("live_idx5", 32'(index), 32'd5);
    chk("live_val1", 32'(valid), 32'd1);
    wait_digit(2'b01);
    chk("live_seg_d0", 32'(segments), 32'h6D);
    wait_digit(2'b10);
    chk("live_seg_d1", 32'(segments), 32'h3F);
    data = 16'h0000;
    run(2);
    chk("live_val0",  32'(valid),   32'd0);
    chk("live_nodat", 32'(no_data), 32'd1);
    wait_digit(2'b01);
    chk("nodat_seg_d0", 32'(segments), 32'h40);
    wait_digit(2'b10);
    chk("nodat_seg_d1", 32'(segments), 32'h00);

    // Latch mode and clear
    mode_latch = 1'b1;
    data = 16'h0004;
    run(2);
    data = 16'h8000;
    run(3);
    chk("latch_hold_idx", 32'(index), 32'd2);
    clear = 1'b1;
    step();
    chk("clear_val0", 32'(valid), 32'd0);
    clear = 1'b0;
    step();
    chk("clear_idx15", 32'(index), 32'd15);
    wait_digit(2'b01);
    chk("clear_seg", 32'(segments), 32'h71);

    // Scan slot stretched by ena low
    count_until_change(n);
    step();
    ena = 1'b0;
    data = 16'h0001;
    run(3);
    chk("frozen_idx", 32'(index), 32'd15);
    ena = 1'b1;
    count_until_change(n);
    chk("slot_len", 32'(4 + n), 32'd7);

    // Reset while holding index 9
    data = 16'h0200;
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
    chk("hold9_idx", 32'(index), 32'd9);
    rst = 1'b1;
    step();
    chk("rst2_val", 32'(valid),    32'd0);
    chk("rst2_den", 32'(digit_en), 32'h1);
    rst = 1'b0;
    run(2);
    chk("recap_idx9", 32'(index), 32'd9);
    chk("recap_val",  32'(valid), 32'd1);

    // Randomized phase
    for (int i = 0; i < 600; i++) begin
      data  = ($urandom_range(0, 3) == 0) ? 16'h0000 : (16'($urandom) >> $urandom_range(0, 15));
      ena   = ($urandom_range(0, 9) != 0);
      clear = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 29) == 0) mode_latch = ~mode_latch;
      rst   = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
